// File: rtl/pcs_rx_align_ctrl.sv
// PCS receive word-alignment controller: resets the code-group sync block,
// waits for lock and bit-slips the PMA deserializer until lock or give-up.
module pcs_rx_align_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_SLIPS     = 10
) (
    input  logic       Clk,
    input  logic       mr_main_reset_n,
    input  logic       power_on,
    input  logic       enable,
    input  logic       code_sync_status,
    output logic       sync_reset,
    output logic       bit_slip,
    output logic       align_done,
    output logic       timeout_err,
    output logic [3:0] slip_count,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESET_SYNC = 3'd1,
        WAIT_LOCK  = 3'd2,
        SLIP       = 3'd3,
        SETTLE     = 3'd4,
        LOCKED     = 3'd5,
        FAIL       = 3'd6
    } state_t;

    localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_TIMEOUT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

    state_t     state, state_n;
    logic [7:0] timer, timer_n;
    logic [3:0] slip_n;
    logic [7:0] relock_n;

    always_ff @(posedge Clk or negedge mr_main_reset_n) begin
        if (!mr_main_reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            slip_count   <= '0;
            relock_count <= '0;
            sync_reset   <= 1'b1;
            bit_slip     <= 1'b0;
            align_done   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            slip_count   <= slip_n;
            relock_count <= relock_n;
            sync_reset   <= (state_n == IDLE) || (state_n == RESET_SYNC) ||
                            (state_n == FAIL);
            bit_slip     <= (state_n == SLIP);
            align_done   <= (state_n == LOCKED);
            timeout_err  <= (state_n == FAIL);
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + 8'd1;
        slip_n   = slip_count;
        relock_n = relock_count;
        if (!power_on || !enable) begin
            // Dropping power or enable overrides everything; relock history is kept.
            state_n = IDLE;
            timer_n = '0;
            slip_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = RESET_SYNC;
                    timer_n = '0;
                end
                RESET_SYNC: begin
                    if (timer == RST_LAST) begin
                        state_n = WAIT_LOCK;
                        timer_n = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (code_sync_status) begin
                        state_n = LOCKED;
                        timer_n = '0;
                    end else if (timer == LOCK_LAST) begin
                        timer_n = '0;
                        if (slip_count < SLIP_MAX) begin
                            state_n = SLIP;
                            slip_n  = slip_count + 4'd1;
                        end else begin
                            state_n = FAIL;
                        end
                    end
                end
                SLIP: begin
                    state_n = SETTLE;
                    timer_n = '0;
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        state_n = RESET_SYNC;
                        timer_n = '0;
                    end
                end
                LOCKED: begin
                    timer_n = '0;
                    if (!code_sync_status) begin
                        // Loss of lock: retry in place without slipping or resetting sync.
                        state_n = WAIT_LOCK;
                        slip_n  = '0;
                        if (relock_count != 8'hFF)
                            relock_n = relock_count + 8'd1;
                    end
                end
                FAIL: begin
                    timer_n = '0;
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                    slip_n  = '0;
                end
            endcase
        end
    end

endmodule
